// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the dm_wait data memory.
package dm_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        EXC_NONE  = 2'd0,
        EXC_ALIGN = 2'd1,
        EXC_RANGE = 2'd2
    } exc_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    function automatic logic is_store(op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_load(op_t op);
        return op <= OP_LW;
    endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte/halfword lane logic: store merge, load extension and alignment check.
module dm_lane
    import dm_pkg::*;
(
    input  op_t         op,
    input  logic [1:0]  lane,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        bsel      = old_word[{lane, 3'b000} +: 8];
        hsel      = lane[1] ? old_word[31:16] : old_word[15:0];
        merged    = old_word;
        load_data = '0;
        misalign  = 1'b0;
        case (op)
            OP_LB:  load_data = {{24{bsel[7]}}, bsel};
            OP_LBU: load_data = {24'd0, bsel};
            OP_LH:  begin
                load_data = {{16{hsel[15]}}, hsel};
                misalign  = lane[0];
            end
            OP_LHU: begin
                load_data = {16'd0, hsel};
                misalign  = lane[0];
            end
            OP_LW:  begin
                load_data = old_word;
                misalign  = (lane != 2'b00);
            end
            OP_SB:  merged[{lane, 3'b000} +: 8] = wdata[7:0];
            OP_SH:  begin
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
                misalign = lane[0];
            end
            OP_SW:  begin
                merged   = wdata;
                misalign = (lane != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_wait.sv
// Wait-state data memory: one load/store per transaction, busy while waiting,
// registered ack with extended load data or a fault code.
module dm_wait
    import dm_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int WAIT           = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        exc,
    output logic [1:0]  exc_code
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int          CNT_W = (WAIT > 1) ? $clog2(WAIT) : 1;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              accept, access, commit, in_wait;

    op_t               op_q;
    logic [31:0]       addr_q, wdata_q, pc_q;
    exc_t              code_q;

    op_t               acc_op;
    logic [31:0]       acc_addr, acc_wdata, acc_pc;
    exc_t              in_code, acc_code;
    logic [ADDR_W-1:0] acc_idx;
    logic [31:0]       old_word, merged, load_data;
    logic              misalign;

    logic [31:0]       mem [DEPTH];

    assign in_wait = (state == S_WAIT);
    assign busy    = in_wait;

    // Outside WAIT the lane sees the incoming request (fault check, and the
    // access itself when WAIT=0); inside WAIT it sees the latched request.
    always_comb begin
        acc_op    = in_wait ? op_q    : op_t'(op);
        acc_addr  = in_wait ? addr_q  : addr;
        acc_wdata = in_wait ? wdata_q : wdata;
        acc_pc    = in_wait ? pc_q    : pc;
        acc_idx   = acc_addr[ADDR_W+1:2];
        old_word  = mem[acc_idx];
    end

    dm_lane u_lane (
        .op        (acc_op),
        .lane      (acc_addr[1:0]),
        .old_word  (old_word),
        .wdata     (acc_wdata),
        .merged    (merged),
        .load_data (load_data),
        .misalign  (misalign)
    );

    always_comb begin
        if (misalign)                         in_code = EXC_ALIGN;
        else if ((addr >> (ADDR_W + 2)) != '0) in_code = EXC_RANGE;
        else                                  in_code = EXC_NONE;
        acc_code = in_wait ? code_q : in_code;
        commit   = access && (acc_code == EXC_NONE) && is_store(acc_op);
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT == 0) begin
                        access     = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = CNT_W'(WAIT - 1);
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    access     = 1'b1;
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ack      <= 1'b0;
            rdata    <= '0;
            exc      <= 1'b0;
            exc_code <= '0;
            op_q     <= OP_LB;
            addr_q   <= '0;
            wdata_q  <= '0;
            pc_q     <= '0;
            code_q   <= EXC_NONE;
            if (CLEAR_ON_RESET != 0) begin
                for (int unsigned i = 0; i < DEPTH; i++) mem[ADDR_W'(i)] <= '0;
            end
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            ack      <= access;
            rdata    <= (access && acc_code == EXC_NONE && is_load(acc_op)) ? load_data : '0;
            exc      <= access && (acc_code != EXC_NONE);
            exc_code <= access ? acc_code : EXC_NONE;
            if (accept) begin
                op_q    <= op_t'(op);
                addr_q  <= addr;
                wdata_q <= wdata;
                pc_q    <= pc;
                code_q  <= in_code;
            end
            if (commit) mem[acc_idx] <= merged;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset && commit)
            $display("%d@%h: *%h <= %h", $time, acc_pc, {acc_addr[31:2], 2'b00}, merged);
    end
`endif

endmodule

// File: doc/dm_wait.md
Name: dm_wait

Overview:
- Parametrised data memory for the pipelined CPU.
- Takes one load/store request per transaction with a byte address and an explicit access type (byte, halfword or word, signed or unsigned).
- Models a configurable number of wait states, stalling the pipeline through busy.
- Returns sign- or zero-extended load data and flags misaligned or out-of-range accesses instead of silently corrupting memory.

Parameters:
ADDR_W, 12, word-address bits; depth = 2**ADDR_W 32-bit words.
WAIT, 1, wait cycles inserted between request acceptance and the memory access (0 allowed).
CLEAR_ON_RESET, 1, when 1 every memory word is zeroed during reset.

Ports:
clk  in  1  clock; all state changes on posedge.
reset  in  1  synchronous, active-low reset; sampled on posedge clk.
req  in  1  request valid; sampled only in IDLE or DONE.
op  in  3  access type: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW.
addr  in  32  byte address.
wdata  in  32  store data; low byte or halfword is used for SB/SH.
pc  in  32  PC of the requesting instruction, used for the trace.
busy  out  1  high while in WAIT; the pipeline must hold its request stable.
ack  out  1  one-cycle completion pulse.
rdata  out  32  extended load data; valid while ack=1, otherwise 0.
exc  out  1  access faulted; valid while ack=1.
exc_code  out  2  0 none, 1 misaligned, 2 out of range.

Behaviour:
- State machine: IDLE, WAIT, DONE.
  - busy = (state==WAIT).
  - ack, rdata, exc and exc_code are registered outputs.
- Acceptance: on a posedge with state IDLE or DONE and req=1, the fields op, addr, wdata and pc are latched.
  - WAIT>0: go to WAIT with cnt=WAIT-1.
  - WAIT=0: perform the access on this same edge and go to DONE.
- In WAIT:
  - cnt>0: decrement.
  - cnt==0: perform the access on this edge and go to DONE.
  - req is ignored throughout WAIT.
- In DONE: ack=1 for exactly this cycle.
  - req=1: accept a new request (back-to-back); with WAIT=0 this gives a sustained rate of one request per cycle.
  - req=0: go to IDLE.
- Latency: ack is high in the cycle following edge t0+WAIT, where t0 is the acceptance edge.
- Fault check, done at acceptance:
  - Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Out of range: addr[31:ADDR_W+2]!=0.
  - Misaligned takes priority over out of range.
  - A faulting request still walks the full WAIT sequence, but performs no memory write, returns rdata=0 and raises exc=1 with its exc_code on ack.
- Store: read-modify-write of word addr[ADDR_W+1:2].
  - SB writes byte lane addr[1:0].
  - SH writes lane addr[1] (bits 15:0 or 31:16).
  - SW writes the whole word.
- Load: extract the byte or halfword selected by addr[1:0].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
  - Load data is captured on the access edge.
- Ordering: a load accepted after a store's ack observes that store's data.
- Trace: on every committed (non-faulting) store, at the access edge, print `$display("%d@%h: *%h <= %h", $time, pc_latched, {addr[31:2],2'b00}, merged_word)`. Faulting stores produce no trace.
- Reset (reset==0 at posedge) has priority over everything:
  - state=IDLE, cnt=0, busy=0, ack=0, rdata=0, exc=0, exc_code=0.
  - Memory is zeroed when CLEAR_ON_RESET=1.
  - A store pending in WAIT is dropped and never committed, even if reset coincides with its access edge.
- Simulation initial contents: all zero.

Decomposition:
- Package dm_pkg holds:
  - op encodings (OP_LB..OP_SW);
  - exc codes (EXC_NONE, EXC_ALIGN, EXC_RANGE);
  - the state enum;
  - helpers is_store(op) and is_load(op).
- One combinational sub-module, dm_lane, takes op, addr[1:0], the old word and wdata and produces:
  - the merged store word;
  - the extended load data;
  - the misalign flag.
- The dm_wait top contains the FSM, counter, array and trace.

Test Plan:
- WAIT=1: SW 0x00000010 <= 0x12345678, then LW 0x10 -> busy high 1 cycle per transaction, ack 2 cycles after acceptance, rdata=0x12345678, one trace line "*00000010 <= 12345678".
- SB 0x11 <= 0xAB onto 0x12345678, then LB 0x11 and LBU 0x11 -> word becomes 0x1234AB78; LB rdata=0xFFFFFFAB; LBU rdata=0x000000AB.
- SH 0x12 <= 0x8001, then LH 0x12 and LHU 0x12 -> word 0x8001AB78; LH rdata=0xFFFF8001; LHU rdata=0x00008001.
- LW 0x13 and SW 0x00004000 with ADDR_W=12 -> exc=1 with exc_code=1, then exc=1 with exc_code=2; no memory change, no trace, rdata=0.
- WAIT=0: four back-to-back SW to 0x0,0x4,0x8,0xC -> ack high for 4 consecutive cycles, busy never high, four trace lines.
- WAIT=3: SW accepted, reset=0 asserted during the second WAIT cycle -> store never committed, next LW returns 0, all outputs 0 the cycle after reset.
